mag_ram_arbiter: RTL and testbench
==================================

Name: mag_ram_arbiter

Overview:
- Controller and arbiter for the single-port gradient-magnitude RAM (ram_mag1: 8-bit data, 16-bit address, 1-bit write enable).
- Sequences one frame fill from the magnitude producer using an internal write pointer.
- Shares the single RAM port with a random-access reader, such as the orientation/descriptor stage, and returns read data with a fixed latency.

Parameters:
- DATA_W, 8: RAM data width.
- ADDR_W, 16: RAM address width.
- FRAME_LEN, 1000: number of words written per frame.
- RD_LAT, 1: RAM read latency in cycles, from the cycle it samples the address to valid ram_dout.
- MAX_WR_BURST, 4: consecutive write grants allowed while a read waits. Used only with RD_STARVE_GUARD_EN.

Ports:
- clk  in  1  system clock, drives the RAM clka.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a frame fill.
- wr_valid  in  1  producer has a word.
- wr_data  in  DATA_W  producer word.
- wr_ready  out  1  write accepted this cycle.
- rd_req  in  1  reader request.
- rd_addr  in  ADDR_W  reader address.
- rd_ack  out  1  read accepted this cycle.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_W  read data.
- busy  out  1  fill in progress.
- frame_done  out  1  one-cycle pulse when the last word of a frame is accepted.
- ram_we  out  1  to RAM wea.
- ram_addr  out  ADDR_W  to RAM addra.
- ram_din  out  DATA_W  to RAM dina.
- ram_dout  in  DATA_W  from RAM douta.

Behaviour:
- Reset: single clock clk; rst_n is asynchronous and active-low. On assertion:
  - state = IDLE, wr_ptr = 0.
  - ram_we = 0, ram_addr = 0, ram_din = 0.
  - rd_valid = 0, frame_done = 0, busy = 0.
  - read-latency pipeline cleared, burst counter = 0.
- States:
  - IDLE or DONE: on start go to FILL and set wr_ptr = 0.
  - FILL: start is ignored.
  - FILL to DONE: on the cycle the write with wr_ptr == FRAME_LEN-1 is accepted. frame_done pulses high in the following cycle.
  - DONE holds until the next start.
  - busy = (state == FILL).
- Arbitration (combinational, same cycle):
  - wr_win = (state == FILL) && wr_valid.
  - wr_ready = wr_win.
  - rd_ack = rd_req && !wr_win.
  - Writes have strict priority. At most one access is granted per cycle. Reads are served in every state.
- RAM drive (registered, one cycle after the grant):
  - Write grant: ram_we = 1, ram_addr = wr_ptr, ram_din = wr_data. wr_ptr increments.
  - Read grant: ram_we = 0, ram_addr = rd_addr.
  - No grant: ram_we = 0; ram_addr and ram_din hold their values.
- Read return:
  - rd_valid is high exactly RD_LAT+1 cycles after the rd_req && rd_ack cycle. This is implemented with a valid shift register of depth RD_LAT+1.
  - rd_data = ram_dout, passed through combinationally; it is qualified only while rd_valid is high.
  - Back-to-back reads give back-to-back rd_valid, in order.
- Boundaries:
  - rd_addr is not range-checked.
  - A read of an address not yet written during FILL returns the old RAM contents.
  - The write pointer never wraps within a frame; it is reset to 0 only by start.
  - When rst_n is asserted mid-frame, the fill aborts and in-flight read valids are dropped.
  - start in the same cycle as a pending read: the read is still acked in that cycle, since state is not yet FILL.

Optional Feature:
- Macro: RD_STARVE_GUARD_EN.
- When defined:
  - A burst counter counts consecutive cycles in which a write is granted while rd_req is high.
  - Once the count reaches MAX_WR_BURST, the next cycle with rd_req high grants the read (rd_ack = 1, wr_ready = 0) and clears the counter.
  - The counter also clears whenever rd_req is low or a read is granted.
- When undefined: strict write priority; a continuous writer can starve the reader for the whole frame.

Test Plan:
- Reset and idle: hold rst_n low, then release with no stimulus -> all outputs 0, state IDLE, no ram_we pulses.
- Frame fill: pulse start, keep wr_valid high with wr_data = 1, 2, 3, … -> 1000 RAM writes at addresses 0..999 with data (addr+1) mod 256, frame_done pulses once, busy falls, wr_ready is 0 afterwards.
- Read-back: in DONE, read addresses 0..999 back-to-back -> rd_valid is high 2 cycles after each ack, rd_data = (addr+1) mod 256, in order, with no gaps.
- Collision, guard undefined: wr_valid and rd_req both high for 10 cycles during FILL -> rd_ack = 0 for all 10 cycles; the read is acked in the first cycle wr_valid drops.
- Starvation guard (RD_STARVE_GUARD_EN, MAX_WR_BURST = 4): continuous writes plus a held rd_req -> pattern of 4 write grants then 1 read grant, repeating; total frame takes 1250 cycles.
- Reset mid-frame: assert rst_n low after 500 writes with 1 read in flight -> no rd_valid and no frame_done; after a new start, writes resume from address 0.

Source files
------------

// File: rtl/mag_ram_arbiter.sv
// ---------------------------------------------------------------------------
// mag_ram_arbiter
//
// Controller and arbiter for the single-port gradient-magnitude RAM.
// A frame fill from the magnitude producer is sequenced with an internal
// write pointer (addresses 0..FRAME_LEN-1). A random-access reader shares
// the same RAM port. Read data comes back RD_LAT+1 cycles after the read is
// acknowledged.
//
// Ports:
//   clk, rst_n          clock (also drives RAM clka), async active-low reset
//   start               pulse, begins a frame fill (ignored while filling)
//   wr_valid/wr_data    producer word; wr_ready = word accepted this cycle
//   rd_req/rd_addr      reader request; rd_ack = read accepted this cycle
//   rd_valid/rd_data    returned read data (rd_data qualified by rd_valid)
//   busy                fill in progress
//   frame_done          one-cycle pulse after the last word is accepted
//   ram_we/ram_addr/
//   ram_din/ram_dout    RAM port (wea, addra, dina, douta)
//
// Optional feature (macro RD_STARVE_GUARD_EN):
//   When defined, after MAX_WR_BURST consecutive write grants with a read
//   waiting, the next cycle with rd_req high grants the read instead.
//   When undefined, writes have strict priority.
// ---------------------------------------------------------------------------
module mag_ram_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 16,
  parameter int FRAME_LEN    = 1000,
  parameter int RD_LAT       = 1,
  parameter int MAX_WR_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);
  localparam int                BURST_W  = $clog2(MAX_WR_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WR_BURST);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [RD_LAT:0]     rd_vld_q, rd_vld_d;
  logic                frame_done_q, frame_done_d;
  logic [BURST_W-1:0]  burst_q, burst_d;

  logic wr_win;
  logic force_rd;
  logic wr_grant;
  logic rd_grant;

  // The burst counter is kept in both builds so reset behaviour is identical;
  // only the guard build lets it override write priority.
`ifdef RD_STARVE_GUARD_EN
  assign force_rd = rd_req && (burst_q >= BURST_MAX);
`else
  assign force_rd = 1'b0;
`endif

  // Same-cycle arbitration: writes win unless the starvation guard fires.
  always_comb begin
    wr_win   = (state_q == FILL) && wr_valid;
    wr_grant = wr_win && !force_rd;
    rd_grant = rd_req && !wr_grant;
  end

  assign wr_ready   = wr_grant;
  assign rd_ack     = rd_grant;
  assign busy       = (state_q == FILL);
  assign frame_done = frame_done_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign rd_valid   = rd_vld_q[RD_LAT];
  assign rd_data    = ram_dout;

  // Next-state logic: fill sequencing, RAM port drive, read-valid pipeline
  // and burst counter.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    frame_done_d = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    rd_vld_d     = '0;
    burst_d      = burst_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      FILL: begin
        if (wr_grant) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // RAM signals are registered, so the RAM sees the access one cycle after
    // the grant. ram_din is left alone on reads.
    if (wr_grant) begin
      ram_we_d   = 1'b1;
      ram_addr_d = wr_ptr_q;
      ram_din_d  = wr_data;
    end else if (rd_grant) begin
      ram_addr_d = rd_addr;
    end

    // One stage for the address register, RD_LAT stages for the RAM itself.
    rd_vld_d[0] = rd_grant;
    for (int i = 1; i <= RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end

    if (!rd_req || rd_grant) begin
      burst_d = '0;
    end else if (wr_grant && (burst_q < BURST_MAX)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // State and datapath registers; reset aborts a fill and drops in-flight
  // read valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rd_vld_q     <= '0;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      frame_done_q <= frame_done_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      rd_vld_q     <= rd_vld_d;
      burst_q      <= burst_d;
    end
  end

endmodule

// File: tb/tb_mag_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mag_ram_arbiter
//
// Bench for mag_ram_arbiter with a behavioural single-port RAM (read-first,
// one cycle latency). A transaction-level model predicts grants, RAM writes
// and read returns each cycle; directed phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_mag_ram_arbiter;

  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 16;
  localparam int FRAME_LEN    = 1000;
  localparam int RD_LAT       = 1;
  localparam int MAX_WR_BURST = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              frame_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  always #5 clk = ~clk;

  mag_ram_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN),
    .RD_LAT(RD_LAT), .MAX_WR_BURST(MAX_WR_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .frame_done(frame_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Power-up RAM contents: a fixed pattern so stale reads are recognisable.
  function automatic logic [7:0] initVal(input int a);
    return a[7:0] ^ 8'hC3;
  endfunction

  // Behavioural RAM, read-first, output registered once (RD_LAT = 1).
  logic [7:0] ram_mem [0:65535];
  bit         ram_wr  [0:65535];
  always @(posedge clk) begin
    ram_dout <= ram_wr[ram_addr] ? ram_mem[ram_addr] : initVal(int'(ram_addr));
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_wr[ram_addr]  <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t        wq[$];
  ev_t        rq[$];
  ev_t        ev;
  logic [7:0] shadow [0:65535];
  int         cyc = 0;
  int         m_mode = 0;
  int         m_ptr = 0;
  bit         m_fd = 0;
  int         m_burst = 0;

  int         n_ram_we = 0;
  int         n_fd = 0;
  int         n_rv = 0;
  logic [7:0] got[$];
  bit         cap_armed = 0;
  int         first_addr = -1;

  // Compare process: predicts every output from the model state plus the
  // current inputs, then advances the model across the coming edge.
  initial begin : compare
    bit e_wr, e_rd, e_rv, e_we, force_rd;
    int was_mode;
    for (int i = 0; i < 65536; i++) shadow[i] = initVal(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_din", ram_din, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        m_mode = 0; m_ptr = 0; m_fd = 0; m_burst = 0;
        wq.delete(); rq.delete();
      end else begin
        force_rd = 1'b0;
`ifdef RD_STARVE_GUARD_EN
        force_rd = rd_req && (m_burst >= MAX_WR_BURST);
`endif
        e_wr = (m_mode == 1) && wr_valid && !force_rd;
        e_rd = rd_req && !e_wr;
        checkOutput("wr_ready", wr_ready, e_wr);
        checkOutput("rd_ack", rd_ack, e_rd);
        checkOutput("busy", busy, m_mode == 1);
        checkOutput("frame_done", frame_done, m_fd);

        e_rv = (rq.size() > 0) && (rq[0].due == cyc);
        checkOutput("rd_valid", rd_valid, e_rv);
        if (e_rv) begin
          ev = rq.pop_front();
          if (rd_valid) checkOutput("rd_data", rd_data, ev.data);
        end

        e_we = (wq.size() > 0) && (wq[0].due == cyc);
        checkOutput("ram_we", ram_we, e_we);
        if (e_we) begin
          ev = wq.pop_front();
          if (ram_we) begin
            checkOutput("ram_addr", ram_addr, ev.addr);
            checkOutput("ram_din", ram_din, ev.data);
          end
        end

        if (ram_we) n_ram_we++;
        if (frame_done) n_fd++;
        if (rd_valid) begin
          n_rv++;
          got.push_back(rd_data);
        end
        if (ram_we && cap_armed) begin
          first_addr = int'(ram_addr);
          cap_armed  = 0;
        end

        was_mode = m_mode;
        m_fd = 0;
        if (e_wr) begin
          wq.push_back('{cyc + 1, m_ptr[15:0], wr_data});
          shadow[m_ptr] = wr_data;
          if (m_ptr == FRAME_LEN - 1) begin
            m_mode = 2;
            m_fd   = 1;
          end
          m_ptr++;
        end
        if (e_rd) rq.push_back('{cyc + 1 + RD_LAT, rd_addr, shadow[rd_addr]});
        if (start && was_mode != 1) begin
          m_mode = 1;
          m_ptr  = 0;
        end
        if (!rd_req || e_rd) m_burst = 0;
        else m_burst++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int wr_idx  = 0;
  int wr_base = 0;

  task automatic applyStimulus(input logic st, input logic wv, input logic [7:0] wd,
                               input logic rq_i, input logic [15:0] ra);
    start    = st;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rq_i;
    rd_addr  = ra;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Streams words until wr_idx reaches target; data = wr_base + index.
  task automatic writeUntil(input int target);
    int budget = 0;
    wr_valid = 1'b1;
    wr_data  = 8'(wr_base + wr_idx);
    while (wr_idx < target && budget < target + 300) begin
      @(negedge clk);
      if (wr_ready) wr_idx++;
      @(posedge clk);
      #1;
      wr_data = 8'(wr_base + wr_idx);
      budget++;
    end
    checkOutput("write_progress", wr_idx, target);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int snap_we, snap_fd, snap_rv, ack_cnt;
`ifdef RD_STARVE_GUARD_EN
    int span, reads, budget;
    bit seen;
`endif
    applyStimulus(0, 0, 8'h00, 0, 16'h0000);
    #1 rst_n = 1'b0;

    // Reset and idle
    repeat (3) stepCycle();
    rst_n = 1'b1;
    repeat (5) stepCycle();
    checkOutput("idle_no_writes", n_ram_we, 0);

    // Frame 1: data = addr + 1
    $display("[TB] frame fill");
    applyStimulus(1, 0, 8'h00, 0, 16'h0000);
    stepCycle();
    start   = 1'b0;
    wr_base = 1;
    wr_idx  = 0;
    writeUntil(FRAME_LEN);
    repeat (3) stepCycle();
    wr_valid = 1'b0;
    stepCycle();
    checkOutput("fill_write_count", n_ram_we, FRAME_LEN);
    checkOutput("fill_frame_done_count", n_fd, 1);
    @(negedge clk);
    checkOutput("busy_after_fill", busy, 0);
    stepCycle();

    // Read-back, back-to-back
    $display("[TB] read-back");
    got.delete();
    rd_req = 1'b1;
    for (int a = 0; a < FRAME_LEN; a++) begin
      rd_addr = 16'(a);
      stepCycle();
    end
    rd_req = 1'b0;
    repeat (4) stepCycle();
    checkOutput("readback_count", got.size(), FRAME_LEN);
    if (got.size() == FRAME_LEN) begin
      checkOutput("readback_addr0", got[0], 1);
      checkOutput("readback_addr255", got[255], 0);
      checkOutput("readback_addr999", got[999], 232);
    end

    // Frame 2: collision between writer and reader
    $display("[TB] collision");
    applyStimulus(1, 0, 8'h00, 0, 16'h0000);
    stepCycle();
    start   = 1'b0;
    wr_base = 7;
    wr_idx  = 0;
    writeUntil(20);
    got.delete();
    rd_req  = 1'b1;
    rd_addr = 16'd900;
    ack_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_ack) ack_cnt++;
      if (wr_ready) wr_idx++;
      @(posedge clk);
      #1;
      wr_data = 8'(wr_base + wr_idx);
    end
`ifndef RD_STARVE_GUARD_EN
    checkOutput("collision_no_ack", ack_cnt, 0);
`endif
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("ack_after_drop", rd_ack, 1);
    stepCycle();
    rd_req = 1'b0;
    repeat (3) stepCycle();
    checkOutput("stale_read_value", got.size() > 0 ? 32'(got[0]) : 32'd999, 133);
    snap_fd = n_fd;
    writeUntil(FRAME_LEN);
    wr_valid = 1'b0;
    repeat (3) stepCycle();
    checkOutput("frame2_done", n_fd, snap_fd + 1);

`ifdef RD_STARVE_GUARD_EN
    // Frame 3: continuous writes with a held read request
    $display("[TB] starvation guard");
    applyStimulus(1, 0, 8'h00, 1, 16'd3);
    stepCycle();
    start    = 1'b0;
    wr_base  = 100;
    wr_idx   = 0;
    wr_valid = 1'b1;
    wr_data  = 8'(wr_base);
    span = 0; reads = 0; seen = 0; budget = 0;
    while (!seen && budget < 1500) begin
      @(negedge clk);
      if (busy || frame_done) span++;
      if (busy && rd_ack) reads++;
      if (wr_ready) wr_idx++;
      if (frame_done) seen = 1;
      @(posedge clk);
      #1;
      wr_data = 8'(wr_base + wr_idx);
      budget++;
    end
    checkOutput("guard_frame_done_seen", seen, 1);
    checkOutput("guard_frame_span", span, 1250);
    checkOutput("guard_read_grants", reads, 249);
    applyStimulus(0, 0, 8'h00, 0, 16'h0000);
    repeat (3) stepCycle();
`endif

    // Reset mid-frame with a read in flight
    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, 8'h00, 0, 16'h0000);
    stepCycle();
    start   = 1'b0;
    wr_base = 50;
    wr_idx  = 0;
    writeUntil(500);
    applyStimulus(0, 0, 8'h00, 1, 16'd10);
    stepCycle();
    rd_req  = 1'b0;
    snap_fd = n_fd;
    snap_rv = n_rv;
    rst_n   = 1'b0;
    repeat (3) stepCycle();
    rst_n = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset_drops_rd_valid", n_rv, snap_rv);
    checkOutput("reset_no_frame_done", n_fd, snap_fd);
    applyStimulus(1, 0, 8'h00, 0, 16'h0000);
    stepCycle();
    start     = 1'b0;
    cap_armed = 1;
    wr_idx    = 0;
    snap_we   = n_ram_we;
    writeUntil(5);
    wr_valid = 1'b0;
    repeat (3) stepCycle();
    checkOutput("restart_first_addr", first_addr, 0);
    checkOutput("restart_write_count", n_ram_we - snap_we, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
